// File: rtl/gmul_ctrl_pkg.sv
// Shared definitions for the stochastic-multiplier sequencing controller.
package gmul_ctrl_pkg;

    localparam int unsigned LEN_LOG2_DEF = 8;
    localparam int unsigned DW_DEF       = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/gmul_win_cnt.sv
// Window cycle index plus ones accumulator for one bitstream window.
module gmul_win_cnt #(
    parameter int unsigned LEN_LOG2 = 8,
    parameter int unsigned DW       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                bit_in,
    output logic [DW-1:0]       idx,
    output logic [LEN_LOG2:0]   count,
    output logic                last
);

    logic [LEN_LOG2-1:0] idx_q;
    logic [LEN_LOG2:0]   cnt_q;

    // Index wraps to 0 after the last step, so it idles at 0 between windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else if (en) begin
            idx_q <= idx_q + 1'b1;
            cnt_q <= cnt_q + (LEN_LOG2 + 1)'(bit_in);
        end
    end

    assign idx   = DW'(idx_q);
    assign count = cnt_q;
    assign last  = en && (idx_q == '1);

endmodule

// File: rtl/gmul_seq_ctrl.sv
// Sequencing controller: operand capture, Sobol window run, ones count result.
// Optional macro GMUL_EARLY_TERM_EN: a zero operand skips LOAD/RUN with result 0.
module gmul_seq_ctrl
    import gmul_ctrl_pkg::*;
#(
    parameter int unsigned LEN_LOG2 = LEN_LOG2_DEF,
    parameter int unsigned DW       = DW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       iA,
    input  logic [DW-1:0]       iB,
    output logic [DW-1:0]       mulA,
    output logic [DW-1:0]       mulB,
    output logic                loadA,
    output logic                loadB,
    output logic [DW-1:0]       seq_idx,
    output logic                seq_en,
    input  logic                bit_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_LOG2:0]   result
);

    state_t              state_q;
    logic                in_ready_q;
    logic                load_q;
    logic                seq_en_q;
    logic                out_valid_q;
    logic [DW-1:0]       mula_q;
    logic [DW-1:0]       mulb_q;

    logic                accept;
    logic                early_term;
    logic                cnt_clr;
    logic                cnt_last;

    assign accept = in_valid && in_ready_q;

`ifdef GMUL_EARLY_TERM_EN
    assign early_term = (iA == '0) || (iB == '0);
`else
    assign early_term = 1'b0;
`endif

    // Cleared while in LOAD so RUN starts from zero; an early-terminated pair clears it for a 0 result.
    assign cnt_clr = (state_q == S_LOAD) || (accept && early_term);

    gmul_win_cnt #(
        .LEN_LOG2 (LEN_LOG2),
        .DW       (DW)
    ) u_win_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (seq_en_q),
        .bit_in (bit_in),
        .idx    (seq_idx),
        .count  (result),
        .last   (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            load_q      <= 1'b0;
            seq_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            mula_q      <= '0;
            mulb_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mula_q     <= iA;
                        mulb_q     <= iB;
                        in_ready_q <= 1'b0;
                        if (early_term) begin
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            load_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    load_q   <= 1'b0;
                    seq_en_q <= 1'b1;
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    if (cnt_last) begin
                        seq_en_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign loadA     = load_q;
    assign loadB     = load_q;
    assign seq_en    = seq_en_q;
    assign out_valid = out_valid_q;
    assign mulA      = mula_q;
    assign mulB      = mulb_q;

endmodule

// File: tb/tb_gmul_seq_ctrl.sv
// Directed self-checking bench for gmul_seq_ctrl (LEN_LOG2=8, DW=8).
module tb_gmul_seq_ctrl;

    localparam int unsigned LEN_LOG2 = 8;
    localparam int unsigned DW       = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       iA;
    logic [DW-1:0]       iB;
    logic [DW-1:0]       mulA;
    logic [DW-1:0]       mulB;
    logic                loadA;
    logic                loadB;
    logic [DW-1:0]       seq_idx;
    logic                seq_en;
    logic                bit_in;
    logic                out_valid;
    logic                out_ready;
    logic [LEN_LOG2:0]   result;

    int n_cmp = 0;
    int n_mis = 0;

    // Observations recorded by the window driver, checked by the test tasks.
    int                obs_lat;
    int                obs_loads;
    int                obs_bad_ctl;
    int                obs_first_bad;
    int                obs_wait;
    logic [LEN_LOG2:0] obs_result;

    always #5 clk = ~clk;

    gmul_seq_ctrl #(
        .LEN_LOG2 (LEN_LOG2),
        .DW       (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .iA        (iA),
        .iB        (iB),
        .mulA      (mulA),
        .mulB      (mulB),
        .loadA     (loadA),
        .loadB     (loadB),
        .seq_idx   (seq_idx),
        .seq_en    (seq_en),
        .bit_in    (bit_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    function automatic logic pat_bit(input int pat, input int k);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (k % 2) == 0;
            default: return (k % 3) == 0;
        endcase
    endfunction

    // Offers a pair, then walks the window: cycle 1 after accept is LOAD, cycles 2..257 are RUN.
    // bit_in is held 1 outside RUN so any stray sampling shows up in the count.
    task automatic do_window(input logic [DW-1:0] a, input logic [DW-1:0] b, input int pat);
        int   c;
        logic exp_load;
        logic exp_run;
        int   exp_idx;
        iA = a;
        iB = b;
        in_valid = 1'b1;
        obs_wait = 0;
        while (in_ready !== 1'b1 && obs_wait < 20) begin
            @(negedge clk);
            obs_wait++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        iA = ~a;
        iB = ~b;
        obs_loads = 0;
        obs_bad_ctl = 0;
        obs_first_bad = -1;
        obs_lat = -1;
        obs_result = '1;
        c = 0;
        while (c < 300) begin
            @(negedge clk);
            c++;
            if (out_valid === 1'b1) begin
                obs_lat = c;
                obs_result = result;
                break;
            end
            if (loadA === 1'b1 && loadB === 1'b1) obs_loads++;
            exp_load = (c == 1);
            exp_run  = (c >= 2) && (c <= 257);
            exp_idx  = exp_run ? c - 2 : 0;
            if (loadA !== exp_load || loadB !== exp_load || seq_en !== exp_run ||
                seq_idx !== DW'(exp_idx) || in_ready !== 1'b0 || mulA !== a || mulB !== b) begin
                if (obs_bad_ctl == 0) obs_first_bad = c;
                obs_bad_ctl++;
            end
            bit_in = exp_run ? pat_bit(pat, c - 2) : 1'b1;
        end
        bit_in = 1'b1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bit_in = 1'b1;
        iA = 8'd33;
        iB = 8'd44;
        #12;
        n_cmp++;
        if ({loadA, loadB, seq_en, out_valid, seq_idx, mulA, mulB, result} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got la=%b lb=%b en=%b ov=%b idx=%0d mA=%0d mB=%0d res=%0d, want all 0",
                     loadA, loadB, seq_en, out_valid, seq_idx, mulA, mulB, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_all_ones();
        do_window(8'd128, 8'd128, 1);
        n_cmp++;
        if (obs_lat !== 258) begin
            n_mis++;
            $display("FAIL ones_latency: got %0d, want 258", obs_lat);
        end
        n_cmp++;
        if (obs_result !== 9'd256) begin
            n_mis++;
            $display("FAIL ones_result: got %0d, want 256", obs_result);
        end
        n_cmp++;
        if (obs_loads !== 1) begin
            n_mis++;
            $display("FAIL ones_load_pulses: got %0d, want 1", obs_loads);
        end
        n_cmp++;
        if (obs_bad_ctl !== 0) begin
            n_mis++;
            $display("FAIL ones_ctl_seq: %0d bad cycles (first at %0d), want 0", obs_bad_ctl, obs_first_bad);
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL ones_return_idle: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_patterns();
        do_window(8'd200, 8'd3, 0);
        n_cmp++;
        if (obs_result !== 9'd0 || obs_lat !== 258) begin
            n_mis++;
            $display("FAIL zeros_result: got res=%0d lat=%0d, want 0/258", obs_result, obs_lat);
        end
        handshake();
        do_window(8'd77, 8'd9, 2);
        n_cmp++;
        if (obs_result !== 9'd128 || obs_bad_ctl !== 0) begin
            n_mis++;
            $display("FAIL alt_result: got res=%0d badctl=%0d, want 128/0", obs_result, obs_bad_ctl);
        end
        handshake();
        do_window(8'd1, 8'd255, 3);
        n_cmp++;
        if (obs_result !== 9'd86) begin
            n_mis++;
            $display("FAIL third_result: got %0d, want 86", obs_result);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int bad;
        do_window(8'd128, 8'd128, 2);
        bad = 0;
        in_valid = 1'b1;
        iA = 8'd5;
        iB = 8'd6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 9'd128 || in_ready !== 1'b0 || mulA !== 8'd128)
                bad++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_mis++;
            $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        iA = 8'd50;
        iB = 8'd60;
        in_valid = 1'b1;
        bit_in = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 102; c++) @(negedge clk);
        n_cmp++;
        if (seq_idx !== 8'd100) begin
            n_mis++;
            $display("FAIL midrun_index: got %0d, want 100", seq_idx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({loadA, loadB, seq_en, out_valid, seq_idx, mulA, mulB, result} !== '0) begin
            n_mis++;
            $display("FAIL midrun_async_clear: la=%b lb=%b en=%b ov=%b idx=%0d mA=%0d mB=%0d res=%0d, want all 0",
                     loadA, loadB, seq_en, out_valid, seq_idx, mulA, mulB, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_mis++;
            $display("FAIL midrun_no_result: %0d bad idle cycles, want 0", bad);
        end
        do_window(8'd90, 8'd90, 1);
        n_cmp++;
        if (obs_result !== 9'd256 || obs_lat !== 258) begin
            n_mis++;
            $display("FAIL midrun_fresh_window: res=%0d lat=%0d, want 256/258", obs_result, obs_lat);
        end
        handshake();
    endtask

    task automatic test_zero_operand();
        do_window(8'd0, 8'd200, 2);
`ifdef GMUL_EARLY_TERM_EN
        n_cmp++;
        if (obs_lat !== 1 || obs_result !== 9'd0 || obs_loads !== 0) begin
            n_mis++;
            $display("FAIL zero_op_early: lat=%0d res=%0d loads=%0d, want 1/0/0", obs_lat, obs_result, obs_loads);
        end
`else
        n_cmp++;
        if (obs_lat !== 258 || obs_result !== 9'd128 || obs_loads !== 1) begin
            n_mis++;
            $display("FAIL zero_op_full: lat=%0d res=%0d loads=%0d, want 258/128/1", obs_lat, obs_result, obs_loads);
        end
`endif
        handshake();
    endtask

    task automatic test_back_to_back();
        do_window(8'd128, 8'd128, 1);
        n_cmp++;
        if (obs_result !== 9'd256) begin
            n_mis++;
            $display("FAIL b2b_first: got %0d, want 256", obs_result);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        iA = 8'd10;
        iB = 8'd20;
        @(negedge clk);
        out_ready = 1'b0;
        do_window(8'd10, 8'd20, 2);
        n_cmp++;
        if (obs_wait !== 0) begin
            n_mis++;
            $display("FAIL b2b_accept_gap: waited %0d cycles, want 0", obs_wait);
        end
        n_cmp++;
        if (obs_result !== 9'd128 || obs_lat !== 258 || obs_bad_ctl !== 0) begin
            n_mis++;
            $display("FAIL b2b_second: res=%0d lat=%0d badctl=%0d, want 128/258/0", obs_result, obs_lat, obs_bad_ctl);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_backpressure();
        test_reset_mid_run();
        test_zero_operand();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gmul_seq_ctrl.md
GMUL_SEQ_CTRL -- requirements
Module: gmul_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_LOG2, default 8, meaning log2 of the bitstream window length in cycles (legal 4..8).
REQ-002 SHALL have parameter DW, default 8, meaning operand and sequence-index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair offered.
REQ-006 SHALL have port in_ready, output, 1, controller can accept an operand pair.
REQ-007 SHALL have port iA, input, DW, operand A (unipolar, value/2^DW).
REQ-008 SHALL have port iB, input, DW, operand B.
REQ-009 SHALL have port mulA, output, DW, operand A to the multiplier.
REQ-010 SHALL have port mulB, output, DW, operand B to the multiplier.
REQ-011 SHALL have port loadA, output, 1, load strobe for multiplier operand A buffer.
REQ-012 SHALL have port loadB, output, 1, load strobe for multiplier operand B buffer.
REQ-013 SHALL have port seq_idx, output, DW, window cycle index that drives both Sobol generators.
REQ-014 SHALL have port seq_en, output, 1, Sobol generators advance this cycle.
REQ-015 SHALL have port bit_in, input, 1, multiplier product bit for the current seq_idx.
REQ-016 SHALL have port out_valid, output, 1, result available.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-018 SHALL have port result, output, LEN_LOG2+1, count of ones over the window (0..2^LEN_LOG2).

Function
REQ-019 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-020 SHALL assert in_ready only in IDLE; in_valid&&in_ready captures iA/iB into mulA/mulB and moves to LOAD.
REQ-021 SHALL assert loadA and loadB together for exactly the single LOAD cycle, then go to RUN.
REQ-022 SHALL in RUN assert seq_en, drive seq_idx from 0 to 2^LEN_LOG2-1 (one step per cycle), and add bit_in to the accumulator every RUN cycle.
REQ-023 SHALL leave RUN after the cycle with seq_idx = 2^LEN_LOG2-1; accumulator width LEN_LOG2+1 so all-ones gives exactly 2^LEN_LOG2, no wrap.
REQ-024 SHALL in DONE assert out_valid with result stable until out_valid&&out_ready, then return to IDLE with out_valid low next cycle.
REQ-025 SHALL clear the accumulator and seq_idx on entry to RUN; mulA/mulB hold until the next capture.
REQ-026 SHALL give latency of 2^LEN_LOG2+2 cycles from accept edge to out_valid rising.
REQ-027 SHALL ignore in_valid outside IDLE and bit_in outside RUN; out_ready outside DONE has no effect.
REQ-028 SHALL keep seq_en low and seq_idx at 0 outside RUN.

Reset
REQ-029 SHALL on rst_n low, asynchronously and at any state including mid-RUN: state IDLE, in_ready 1 after release, loadA/loadB/seq_en/out_valid 0, seq_idx/mulA/mulB/result/accumulator 0.
REQ-030 SHALL discard any partial window on reset; no result is emitted for it.

Configuration
REQ-031 SHALL support macro GMUL_EARLY_TERM_EN.
REQ-032 With GMUL_EARLY_TERM_EN defined, a captured pair with iA==0 or iB==0 SHALL go IDLE -> DONE directly with result 0, no loadA/loadB pulse and no RUN (latency 1 cycle).
REQ-033 Without it, every pair SHALL follow the full IDLE-LOAD-RUN-DONE path.

Structure
REQ-034 SHALL place the FSM state enum and LEN_LOG2/DW defaults in shared package gmul_ctrl_pkg.
REQ-035 SHALL implement the window counter plus ones accumulator as sub-module gmul_win_cnt (clear, enable, bit in; index, count, last out).

Verification
REQ-036 Accept iA=128,iB=128, bit_in held 1 -> loadA/loadB one cycle, 256 RUN cycles, result=256, out_valid at accept+258.
REQ-037 bit_in held 0 -> result=0; alternating 1/0 starting with 1 -> result=128.
REQ-038 out_ready held low 10 cycles in DONE -> out_valid and result stable, in_ready stays 0; then out_ready=1 -> IDLE next cycle.
REQ-039 rst_n pulsed low at seq_idx=100 -> all outputs 0 immediately; next operand pair produces full fresh window result.
REQ-040 GMUL_EARLY_TERM_EN defined, iA=0,iB=200 -> out_valid next cycle, result=0, no loadA; undefined -> full 258-cycle path, result equals bit_in count.
REQ-041 Back-to-back pairs with out_ready=1 -> second pair accepted the cycle after handshake, no bit_in sample lost or double-counted.
